// File: rtl/ssp_tx_arbiter_pkg.sv
// ssp_pkg -- shared definitions for the SSP transmit arbiter slice.
//   ssp_state_t        : arbiter FSM encoding (IDLE / GRANT0 / GRANT1)
//   SSP_BURST_LEN_DEF  : default maximum pops per grant
//   SSP_WORD_W         : SSP word width
package ssp_pkg;

  localparam int SSP_WORD_W        = 8;
  localparam int SSP_BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } ssp_state_t;

endpackage

// File: rtl/ssp_tx_arbiter_if.sv
// ssp_tx_arbiter_if -- bundle of the two transmit sources and the serializer
// side of the SSP transmit arbiter.
//   slave  : arbiter view (takes source heads + TxNextWord, drives pops/Tx*)
//   master : environment view (sources and serializer)
interface ssp_tx_arbiter_if import ssp_pkg::*; ();

  logic [SSP_WORD_W-1:0] REQ0_DATA;
  logic                  REQ0_VALID;
  logic                  REQ0_NEXT;
  logic [SSP_WORD_W-1:0] REQ1_DATA;
  logic                  REQ1_VALID;
  logic                  REQ1_NEXT;
  logic [SSP_WORD_W-1:0] TxData;
  logic                  TxValidWord;
  logic                  TxIsEmpty;
  logic                  TxNextWord;
  logic                  GRANT_ID;
  logic                  BUSY;

  modport slave (
    input  REQ0_DATA, REQ0_VALID, REQ1_DATA, REQ1_VALID, TxNextWord,
    output REQ0_NEXT, REQ1_NEXT, TxData, TxValidWord, TxIsEmpty, GRANT_ID, BUSY
  );

  modport master (
    output REQ0_DATA, REQ0_VALID, REQ1_DATA, REQ1_VALID, TxNextWord,
    input  REQ0_NEXT, REQ1_NEXT, TxData, TxValidWord, TxIsEmpty, GRANT_ID, BUSY
  );

endinterface

// File: rtl/ssp_tx_arbiter_rr_pick.sv
// ssp_rr_pick -- two-way round-robin winner select.
//   valid0/valid1 : request bits
//   lastId        : source granted most recently
//   winner        : chosen source; on a tie the one that was not last,
//                   otherwise whichever is valid (0 when neither)
module ssp_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic lastId,
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    if (valid0 && valid1) winner = ~lastId;
    else if (valid1)      winner = 1'b1;
  end

endmodule

// File: rtl/ssp_tx_arbiter.sv
// ssp_tx_arbiter -- round-robin arbiter feeding one SSP serializer from two
// transmit sources.
//   PCLK  : clock
//   CLEAR : asynchronous active-high reset
//   bus   : ssp_tx_arbiter_if.slave (source heads/pops, Tx word, grant status)
// A grant lasts until its source runs dry or, with SSP_TX_ARB_BURST_EN
// defined, BURST_LEN words have been popped. Without the macro every pop
// releases the grant and BURST_LEN is ignored. Each release costs exactly
// one IDLE cycle in which the next winner is picked.
module ssp_tx_arbiter import ssp_pkg::*; #(
  parameter int BURST_LEN = SSP_BURST_LEN_DEF
) (
  input  logic             PCLK,
  input  logic             CLEAR,
  ssp_tx_arbiter_if.slave  bus
);

  if (BURST_LEN < 1 || BURST_LEN > 16) begin : gBadLen
    $error("ssp_tx_arbiter: BURST_LEN out of range 1..16");
  end

  ssp_state_t state, nextState;
  logic       lastId;
  logic       winner;
  logic       pop;
  logic       lastPop;

  ssp_rr_pick uPick (
    .valid0 (bus.REQ0_VALID),
    .valid1 (bus.REQ1_VALID),
    .lastId (lastId),
    .winner (winner)
  );

  // Outputs follow the granted source combinationally; IDLE (and therefore
  // CLEAR, which forces IDLE asynchronously) presents an all-zero word.
  always_comb begin
    bus.TxData      = '0;
    bus.TxValidWord = 1'b0;
    bus.GRANT_ID    = 1'b0;
    bus.BUSY        = 1'b0;
    case (state)
      GRANT0: begin
        bus.TxData      = bus.REQ0_DATA;
        bus.TxValidWord = bus.REQ0_VALID;
        bus.BUSY        = 1'b1;
      end
      GRANT1: begin
        bus.TxData      = bus.REQ1_DATA;
        bus.TxValidWord = bus.REQ1_VALID;
        bus.GRANT_ID    = 1'b1;
        bus.BUSY        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.TxIsEmpty = ~(bus.REQ0_VALID | bus.REQ1_VALID);

  // TxValidWord is low in IDLE, so a stray TxNextWord there never pops.
  assign pop           = bus.TxNextWord & bus.TxValidWord;
  assign bus.REQ0_NEXT = pop & (state == GRANT0);
  assign bus.REQ1_NEXT = pop & (state == GRANT1);

`ifdef SSP_TX_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  logic [CNT_W-1:0] cnt;

  assign lastPop = (cnt == CNT_W'(BURST_LEN - 1));

  // Zeroed in IDLE so every grant starts counting from 0; the final pop of a
  // burst wraps to 0 rather than reaching BURST_LEN.
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR)                cnt <= '0;
    else if (state == IDLE)   cnt <= '0;
    else if (pop)             cnt <= lastPop ? '0 : cnt + CNT_W'(1);
  end
`else
  assign lastPop = 1'b1;
`endif

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state  <= IDLE;
      lastId <= 1'b1;  // source 0 wins the first tie
    end else begin
      state <= nextState;
      if (state == IDLE && (bus.REQ0_VALID || bus.REQ1_VALID)) lastId <= winner;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.REQ0_VALID || bus.REQ1_VALID) nextState = winner ? GRANT1 : GRANT0;
      end
      GRANT0: begin
        if (pop ? lastPop : !bus.REQ0_VALID) nextState = IDLE;
      end
      GRANT1: begin
        if (pop ? lastPop : !bus.REQ1_VALID) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// tb_ssp_tx_arbiter -- self-checking bench for ssp_tx_arbiter.
// Reset / first-tie / drain / mid-burst CLEAR are stepped cycle by cycle;
// the alternating-burst traffic is checked against a queue of expected pops
// (source id + word) built up front from the round-robin rule.
// Runs with or without SSP_TX_ARB_BURST_EN defined.
module tb_ssp_tx_arbiter;
  import ssp_pkg::*;

`ifdef SSP_TX_ARB_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif

  logic PCLK = 1'b0;
  logic CLEAR = 1'b1;
  always #5 PCLK = ~PCLK;

  ssp_tx_arbiter_if bus ();

  ssp_tx_arbiter #(.BURST_LEN(4)) dut (
    .PCLK  (PCLK),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  typedef struct {
    logic       id;
    logic [7:0] data;
  } expPop_t;

  expPop_t sb[$];
  int nChk  = 0;
  int nPass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulseClear();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
  endtask

  logic [7:0] d0, d1;
  logic       n0, n1;
  logic       expIdle;
  int         popIdx, cyc, c0, c1;
  expPop_t    e;

  initial begin
    // ---------------- reset with both sources valid
    bus.REQ0_DATA  = 8'hA5;
    bus.REQ1_DATA  = 8'h5A;
    bus.REQ0_VALID = 1'b1;
    bus.REQ1_VALID = 1'b1;
    bus.TxNextWord = 1'b1;
    @(negedge PCLK);
    chk("rst busy",  32'(bus.BUSY), 0);
    chk("rst valid", 32'(bus.TxValidWord), 0);
    chk("rst data",  32'(bus.TxData), 0);
    chk("rst gid",   32'(bus.GRANT_ID), 0);
    chk("rst next0", 32'(bus.REQ0_NEXT), 0);
    chk("rst next1", 32'(bus.REQ1_NEXT), 0);
    chk("rst empty", 32'(bus.TxIsEmpty), 0);

    // ---------------- first tie after reset goes to source 0
    step();
    CLEAR = 1'b0;
    bus.TxNextWord = 1'b0;
    @(negedge PCLK);
    chk("arb idle busy", 32'(bus.BUSY), 0);
    step();
    @(negedge PCLK);
    chk("tie busy", 32'(bus.BUSY), 1);
    chk("tie gid",  32'(bus.GRANT_ID), 0);
    chk("tie data", 32'(bus.TxData), 32'h A5);
    chk("tie valid", 32'(bus.TxValidWord), 1);

    // ---------------- alternating bursts, both sources always valid
    step();
    pulseClear();
    d0 = 8'h10; d1 = 8'h80; c0 = 0; c1 = 0;
    for (int k = 0; k < 16; k++) begin
      e.id = 1'((k / BL) % 2);
      if (e.id) begin e.data = 8'h80 + 8'(c1); c1++; end
      else      begin e.data = 8'h10 + 8'(c0); c0++; end
      sb.push_back(e);
    end
    expIdle = 1'b0; popIdx = 0; cyc = 0;
    while (sb.size() > 0 && cyc < 400) begin
      bus.REQ0_DATA  = d0;
      bus.REQ1_DATA  = d1;
      bus.TxNextWord = (cyc % 3 == 2);
      @(negedge PCLK);
      if (expIdle) begin
        chk("burst gap", 32'(bus.BUSY), 0);
        expIdle = 1'b0;
      end
      n0 = bus.REQ0_NEXT;
      n1 = bus.REQ1_NEXT;
      if (n0 || n1) begin
        e = sb.pop_front();
        chk("pop gid",  32'(bus.GRANT_ID), 32'(e.id));
        chk("pop next", 32'(n1), 32'(e.id));
        chk("pop data", 32'(bus.TxData), 32'(e.data));
        chk("pop excl", 32'(n0 & n1), 0);
        popIdx++;
        if (popIdx % BL == 0) expIdle = 1'b1;
      end
      step();
      if (n0) d0++;
      if (n1) d1++;
      cyc++;
    end
    chk("sb drained", 32'(sb.size()), 0);

    // ---------------- source 0 drains mid-burst
    bus.TxNextWord = 1'b0;
    bus.REQ1_VALID = 1'b0;
    d0 = 8'h30;
    bus.REQ0_DATA = d0;
    pulseClear();
    step();
    @(negedge PCLK);
    chk("drain grant", 32'(bus.BUSY), 1);
    for (int i = 0; i < ((BL >= 3) ? 2 : 0); i++) begin
      step();
      bus.TxNextWord = 1'b1;
      @(negedge PCLK);
      chk("drain pop",  32'(bus.REQ0_NEXT), 1);
      chk("drain data", 32'(bus.TxData), 32'(d0));
      step();
      bus.TxNextWord = 1'b0;
      d0++;
      bus.REQ0_DATA = d0;
    end
    step();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_DATA  = 8'h C3;
    bus.TxNextWord = 1'b1;
    @(negedge PCLK);
    chk("dry busy",  32'(bus.BUSY), 1);
    chk("dry valid", 32'(bus.TxValidWord), 0);
    chk("dry next0", 32'(bus.REQ0_NEXT), 0);
    step();
    @(negedge PCLK);
    chk("dry idle",  32'(bus.BUSY), 0);
    chk("idle next", 32'(bus.REQ1_NEXT | bus.REQ0_NEXT), 0);
    step();
    bus.TxNextWord = 1'b0;
    @(negedge PCLK);
    chk("g1 busy", 32'(bus.BUSY), 1);
    chk("g1 gid",  32'(bus.GRANT_ID), 1);
    chk("g1 data", 32'(bus.TxData), 32'h C3);

    // ---------------- CLEAR in GRANT1 after one pop
    step();
    bus.REQ0_VALID = 1'b1;
    bus.REQ0_DATA  = 8'h 44;
    bus.TxNextWord = 1'b1;
    @(negedge PCLK);
    chk("clr pop1", 32'(bus.REQ1_NEXT), 1);
    step();
`ifdef SSP_TX_ARB_BURST_EN
    chk("clr pre busy", 32'(bus.BUSY), 1);
`endif
    CLEAR = 1'b1;
    #1;
    chk("clr busy",  32'(bus.BUSY), 0);
    chk("clr next1", 32'(bus.REQ1_NEXT), 0);
    chk("clr data",  32'(bus.TxData), 0);
    step();
    CLEAR = 1'b0;
    bus.TxNextWord = 1'b0;
    @(negedge PCLK);
    chk("clr idle", 32'(bus.BUSY), 0);
    step();
    @(negedge PCLK);
    chk("clr regrant busy", 32'(bus.BUSY), 1);
    chk("clr regrant gid",  32'(bus.GRANT_ID), 0);
    chk("clr regrant data", 32'(bus.TxData), 32'h 44);

    // ---------------- TxIsEmpty with neither source valid
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    #1;
    chk("empty", 32'(bus.TxIsEmpty), 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
